coeff_loader: RTL and testbench

COEFF_LOADER -- requirements
Module: coeff_loader

---
 rtl/coeff_loader_if.sv | 23 ++
 rtl/coeff_loader.sv | 158 +++++++++++++++
 tb/tb_coeff_loader.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coeff_loader_if.sv
// Coefficient stream handshake plus RAM write bus between the coefficient source, coeff_loader and the FIR RAM.
// slave = the loader side, master = the environment (source + RAM).
interface coeff_loader_if #(
   parameter int DATA_W = 16
) ();
   logic                     iCoeffValid;
   logic signed [DATA_W-1:0] iCoeffData;
   logic                     oCoeffReady;
   logic                     oCsnRam;
   logic                     oWrnRam;
   logic [5:0]               oAddrRam;
   logic signed [DATA_W-1:0] oWrDtRam;

   modport slave (
      input  iCoeffValid, iCoeffData,
      output oCoeffReady, oCsnRam, oWrnRam, oAddrRam, oWrDtRam
   );

   modport master (
      output iCoeffValid, iCoeffData,
      input  oCoeffReady, oCsnRam, oWrnRam, oAddrRam, oWrDtRam
   );
endinterface

// File: rtl/coeff_loader.sv
// coeff_loader: loads FIR coefficients from a valid/ready stream into coefficient RAM, one write per beat.
// Optional macro COEFF_LOADER_SYMM_EN: load half the taps and mirror each beat to its symmetric address.
module coeff_loader #(
   parameter int NUM_TAPS = 33,
   parameter int DATA_W   = 16,
   parameter int TIMEOUT  = 1023
) (
   input  logic          iClk_12M,
   input  logic          iRsn,
   input  logic          iLoadStart,
   coeff_loader_if.slave bus,
   output logic          oCoeffiUpdateFlag,
   output logic          oBusy,
   output logic          oLoadDone,
   output logic          oErr
);
   localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
`ifdef COEFF_LOADER_SYMM_EN
   localparam logic [5:0] TOP_ADDR = 6'(NUM_TAPS - 1);
   localparam logic [5:0] LAST_IDX = 6'((NUM_TAPS - 1) / 2);
`else
   localparam logic [5:0] LAST_IDX = 6'(NUM_TAPS - 1);
`endif

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
`ifdef COEFF_LOADER_SYMM_EN
      ST_MIRROR,
`endif
      ST_DONE
   } state_t;

   state_t                   state_q;
   logic [5:0]               beat_cnt_q;
   logic [5:0]               beat_cnt_d;
   logic [TO_W-1:0]          idle_cnt_q;
   logic [TO_W-1:0]          idle_cnt_d;
   logic                     ready_q;
   logic                     csn_q;
   logic                     wrn_q;
   logic [5:0]               addr_q;
   logic signed [DATA_W-1:0] wrdt_q;
   logic                     flag_q;
   logic                     busy_q;
   logic                     done_q;
   logic                     err_q;
   logic                     beat_acc;
   logic                     is_last;

   assign beat_acc   = bus.iCoeffValid & ready_q;
   assign is_last    = (beat_cnt_q == LAST_IDX);
   assign beat_cnt_d = beat_cnt_q + 6'd1;
   assign idle_cnt_d = idle_cnt_q + 1'b1;

`ifdef COEFF_LOADER_SYMM_EN
   logic is_centre;
   assign is_centre = ((TOP_ADDR - beat_cnt_q) == beat_cnt_q);
`endif

   always_ff @(posedge iClk_12M) begin
      if (iRsn) begin
         state_q    <= ST_IDLE;
         beat_cnt_q <= '0;
         idle_cnt_q <= '0;
         ready_q    <= 1'b0;
         csn_q      <= 1'b1;
         wrn_q      <= 1'b1;
         addr_q     <= '0;
         wrdt_q     <= '0;
         flag_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         // RAM strobes are single-cycle; every write branch below re-asserts them.
         csn_q  <= 1'b1;
         wrn_q  <= 1'b1;
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (iLoadStart) begin
                  state_q    <= ST_LOAD;
                  beat_cnt_q <= '0;
                  idle_cnt_q <= '0;
                  err_q      <= 1'b0;
                  flag_q     <= 1'b1;
                  busy_q     <= 1'b1;
                  ready_q    <= 1'b1;
               end
            end
            ST_LOAD: begin
               if (beat_acc) begin
                  csn_q      <= 1'b0;
                  wrn_q      <= 1'b0;
                  addr_q     <= beat_cnt_q;
                  wrdt_q     <= bus.iCoeffData;
                  beat_cnt_q <= beat_cnt_d;
                  idle_cnt_q <= '0;
`ifdef COEFF_LOADER_SYMM_EN
                  if (!is_centre) begin
                     state_q <= ST_MIRROR;
                     ready_q <= 1'b0;
                  end else
`endif
                  if (is_last) begin
                     state_q <= ST_DONE;
                     ready_q <= 1'b0;
                     done_q  <= 1'b1;
                     flag_q  <= 1'b0;
                     busy_q  <= 1'b0;
                  end
               end else if (idle_cnt_q == TO_LAST) begin
                  // Source stalled too long: abort, keep what was already written.
                  state_q <= ST_IDLE;
                  err_q   <= 1'b1;
                  ready_q <= 1'b0;
                  flag_q  <= 1'b0;
                  busy_q  <= 1'b0;
               end else begin
                  idle_cnt_q <= idle_cnt_d;
               end
            end
`ifdef COEFF_LOADER_SYMM_EN
            ST_MIRROR: begin
               // addr_q/wrdt_q still hold beat k; reuse the data for address NUM_TAPS-1-k.
               csn_q  <= 1'b0;
               wrn_q  <= 1'b0;
               addr_q <= TOP_ADDR - addr_q;
               if (addr_q == LAST_IDX) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                  flag_q  <= 1'b0;
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= ST_LOAD;
                  ready_q <= 1'b1;
               end
            end
`endif
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.oCoeffReady = ready_q;
   assign bus.oCsnRam     = csn_q;
   assign bus.oWrnRam     = wrn_q;
   assign bus.oAddrRam    = addr_q;
   assign bus.oWrDtRam    = wrdt_q;
   assign oCoeffiUpdateFlag = flag_q;
   assign oBusy           = busy_q;
   assign oLoadDone       = done_q;
   assign oErr            = err_q;
endmodule

// File: tb/tb_coeff_loader.sv
// Directed bench for coeff_loader: reset, linear loads, stalls, timeout, mid-load reset, symmetric mode.
module tb_coeff_loader;
   localparam int DATA_W = 16;

   logic clk = 1'b0;
   logic rsn;
   logic load_start;
   logic flag, busy, done, err;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int wr_total  = 0;
   int done_cnt  = 0;
   logic [15:0] ram_q    [64];
   int          ram_hits [64];

   coeff_loader_if #(.DATA_W(DATA_W)) bus ();

   coeff_loader #(.NUM_TAPS(33), .DATA_W(DATA_W), .TIMEOUT(1023)) dut (
      .iClk_12M          (clk),
      .iRsn              (rsn),
      .iLoadStart        (load_start),
      .bus               (bus),
      .oCoeffiUpdateFlag (flag),
      .oBusy             (busy),
      .oLoadDone         (done),
      .oErr              (err)
   );

   always #5 clk = ~clk;

   // Records every RAM write and done pulse mid-cycle, clear of both clock edges.
   always @(posedge clk) begin
      #3;
      if (bus.oCsnRam === 1'b0 && bus.oWrnRam === 1'b0) begin
         wr_total++;
         ram_q[bus.oAddrRam] = bus.oWrDtRam;
         ram_hits[bus.oAddrRam]++;
      end
      if (done === 1'b1) done_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_log();
      wr_total = 0;
      done_cnt = 0;
      for (int i = 0; i < 64; i++) begin
         ram_q[i]    = '0;
         ram_hits[i] = 0;
      end
   endtask

   task automatic start_load();
      @(negedge clk);
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
   endtask

   task automatic test_reset();
      rsn = 1'b1;
      load_start = 1'b0;
      bus.iCoeffValid = 1'b0;
      bus.iCoeffData = '0;
      repeat (3) @(negedge clk);
      total_cnt++;
      if ({bus.oCsnRam, bus.oWrnRam, bus.oAddrRam, bus.oWrDtRam} !== {2'b11, 6'd0, 16'd0}) begin
         $display("FAIL reset_ram got csn=%b wrn=%b addr=%0d data=%h want 1 1 0 0000",
                  bus.oCsnRam, bus.oWrnRam, bus.oAddrRam, bus.oWrDtRam);
      end else pass_cnt++;
      total_cnt++;
      if ({bus.oCoeffReady, flag, busy, done, err} !== 5'b00000) begin
         $display("FAIL reset_ctrl got ready/flag/busy/done/err=%b want 00000",
                  {bus.oCoeffReady, flag, busy, done, err});
      end else pass_cnt++;
      load_start = 1'b1;
      bus.iCoeffValid = 1'b1;
      @(negedge clk);
      total_cnt++;
      if ({busy, flag, bus.oCoeffReady, bus.oCsnRam} !== 4'b0001) begin
         $display("FAIL reset_override got busy/flag/ready/csn=%b want 0001",
                  {busy, flag, bus.oCoeffReady, bus.oCsnRam});
      end else pass_cnt++;
      load_start = 1'b0;
      bus.iCoeffValid = 1'b0;
      rsn = 1'b0;
      @(negedge clk);
      total_cnt++;
      if ({busy, bus.oCoeffReady} !== 2'b00) begin
         $display("FAIL reset_release got busy/ready=%b want 00", {busy, bus.oCoeffReady});
      end else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      clear_log();
      start_load();
      total_cnt++;
      if ({flag, busy, bus.oCoeffReady} !== 3'b111) begin
         $display("FAIL b2b_start got flag/busy/ready=%b want 111", {flag, busy, bus.oCoeffReady});
      end else pass_cnt++;
      for (int k = 0; k < 33; k++) begin
         bus.iCoeffValid = 1'b1;
         bus.iCoeffData = 16'(k + 1);
         @(negedge clk);
         total_cnt++;
         if ({bus.oCsnRam, bus.oWrnRam, bus.oAddrRam, bus.oWrDtRam} !== {2'b00, 6'(k), 16'(k + 1)}) begin
            $display("FAIL b2b_write k=%0d got csn=%b wrn=%b addr=%0d data=%h want 0 0 %0d %h",
                     k, bus.oCsnRam, bus.oWrnRam, bus.oAddrRam, bus.oWrDtRam, k, 16'(k + 1));
         end else pass_cnt++;
         total_cnt++;
         if (k < 32) begin
            if (flag !== 1'b1) begin
               $display("FAIL b2b_flag k=%0d got flag=%b want 1", k, flag);
            end else pass_cnt++;
         end else begin
            if ({done, flag, busy, bus.oCoeffReady} !== 4'b1000) begin
               $display("FAIL b2b_done got done/flag/busy/ready=%b want 1000",
                        {done, flag, busy, bus.oCoeffReady});
            end else pass_cnt++;
         end
      end
      bus.iCoeffValid = 1'b0;
      @(negedge clk);
      total_cnt++;
      if ({done, bus.oCsnRam, busy} !== 3'b010) begin
         $display("FAIL b2b_idle got done/csn/busy=%b want 010", {done, bus.oCsnRam, busy});
      end else pass_cnt++;
      total_cnt++;
      if (wr_total !== 33 || done_cnt !== 1) begin
         $display("FAIL b2b_totals got writes=%0d done_pulses=%0d want 33 1", wr_total, done_cnt);
      end else pass_cnt++;
   endtask

   task automatic test_toggle();
      int bad;
      clear_log();
      start_load();
      for (int k = 0; k < 33; k++) begin
         bus.iCoeffValid = 1'b1;
         bus.iCoeffData = 16'(16'hF000 + k);
         @(negedge clk);
         total_cnt++;
         if ({bus.oCsnRam, bus.oAddrRam, bus.oWrDtRam} !== {1'b0, 6'(k), 16'(16'hF000 + k)}) begin
            $display("FAIL toggle_write k=%0d got csn=%b addr=%0d data=%h want 0 %0d %h",
                     k, bus.oCsnRam, bus.oAddrRam, bus.oWrDtRam, k, 16'(16'hF000 + k));
         end else pass_cnt++;
         bus.iCoeffValid = 1'b0;
         @(negedge clk);
         total_cnt++;
         if ({bus.oCsnRam, bus.oWrnRam, bus.oAddrRam} !== {2'b11, 6'(k)}) begin
            $display("FAIL toggle_gap k=%0d got csn=%b wrn=%b addr=%0d want 1 1 %0d",
                     k, bus.oCsnRam, bus.oWrnRam, bus.oAddrRam, k);
         end else pass_cnt++;
      end
      bad = 0;
      for (int a = 0; a < 33; a++) begin
         if (ram_hits[a] != 1 || ram_q[a] != 16'(16'hF000 + a)) bad++;
      end
      total_cnt++;
      if (bad != 0 || wr_total !== 33 || done_cnt !== 1) begin
         $display("FAIL toggle_contig got bad_words=%0d writes=%0d done_pulses=%0d want 0 33 1",
                  bad, wr_total, done_cnt);
      end else pass_cnt++;
   endtask

   task automatic test_timeout();
      int bad;
      clear_log();
      start_load();
      for (int k = 0; k < 10; k++) begin
         bus.iCoeffValid = 1'b1;
         bus.iCoeffData = 16'(16'h0200 + k);
         @(negedge clk);
      end
      bus.iCoeffValid = 1'b0;
      repeat (1022) @(negedge clk);
      total_cnt++;
      if ({err, busy, flag} !== 3'b011) begin
         $display("FAIL to_before got err/busy/flag=%b want 011", {err, busy, flag});
      end else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({err, busy, flag, bus.oCoeffReady} !== 4'b1000) begin
         $display("FAIL to_abort got err/busy/flag/ready=%b want 1000",
                  {err, busy, flag, bus.oCoeffReady});
      end else pass_cnt++;
      bus.iCoeffValid = 1'b1;
      repeat (5) @(negedge clk);
      bus.iCoeffValid = 1'b0;
      bad = 0;
      for (int a = 0; a < 10; a++) begin
         if (ram_hits[a] != 1 || ram_q[a] != 16'(16'h0200 + a)) bad++;
      end
      total_cnt++;
      if (bad != 0 || wr_total !== 10 || ram_hits[10] != 0 || done_cnt !== 0 || err !== 1'b1) begin
         $display("FAIL to_writes got bad_words=%0d writes=%0d hits10=%0d done_pulses=%0d err=%b want 0 10 0 0 1",
                  bad, wr_total, ram_hits[10], done_cnt, err);
      end else pass_cnt++;
      start_load();
      total_cnt++;
      if ({err, busy} !== 2'b01) begin
         $display("FAIL to_errclr got err/busy=%b want 01", {err, busy});
      end else pass_cnt++;
      rsn = 1'b1;
      @(negedge clk);
      rsn = 1'b0;
   endtask

   task automatic test_reset_midload();
      clear_log();
      start_load();
      for (int k = 0; k < 20; k++) begin
         bus.iCoeffValid = 1'b1;
         bus.iCoeffData = 16'(16'h0300 + k);
         @(negedge clk);
      end
      bus.iCoeffData = 16'h0314;
      rsn = 1'b1;
      @(negedge clk);
      total_cnt++;
      if ({bus.oCsnRam, bus.oWrnRam, bus.oAddrRam, bus.oWrDtRam, bus.oCoeffReady, flag, busy, done, err}
          !== {2'b11, 6'd0, 16'd0, 5'b00000}) begin
         $display("FAIL rst_mid got csn=%b wrn=%b addr=%0d data=%h ready/flag/busy/done/err=%b want 1 1 0 0000 00000",
                  bus.oCsnRam, bus.oWrnRam, bus.oAddrRam, bus.oWrDtRam,
                  {bus.oCoeffReady, flag, busy, done, err});
      end else pass_cnt++;
      rsn = 1'b0;
      repeat (3) @(negedge clk);
      bus.iCoeffValid = 1'b0;
      total_cnt++;
      if (wr_total !== 20 || ram_hits[20] != 0 || busy !== 1'b0) begin
         $display("FAIL rst_nowrite got writes=%0d hits20=%0d busy=%b want 20 0 0",
                  wr_total, ram_hits[20], busy);
      end else pass_cnt++;
   endtask

   task automatic test_start_ignored();
      clear_log();
      start_load();
      for (int k = 0; k < 33; k++) begin
         bus.iCoeffValid = 1'b1;
         bus.iCoeffData = 16'(16'h0400 + k);
         load_start = (k == 5 || k == 20);
         @(negedge clk);
         total_cnt++;
         if ({bus.oCsnRam, bus.oAddrRam, bus.oWrDtRam} !== {1'b0, 6'(k), 16'(16'h0400 + k)}) begin
            $display("FAIL restart_write k=%0d got csn=%b addr=%0d data=%h want 0 %0d %h",
                     k, bus.oCsnRam, bus.oAddrRam, bus.oWrDtRam, k, 16'(16'h0400 + k));
         end else pass_cnt++;
      end
      load_start = 1'b0;
      bus.iCoeffValid = 1'b0;
      repeat (2) @(negedge clk);
      total_cnt++;
      if (wr_total !== 33 || done_cnt !== 1 || busy !== 1'b0) begin
         $display("FAIL restart_totals got writes=%0d done_pulses=%0d busy=%b want 33 1 0",
                  wr_total, done_cnt, busy);
      end else pass_cnt++;
   endtask

`ifdef COEFF_LOADER_SYMM_EN
   task automatic test_symm();
      int bad;
      int guard;
      clear_log();
      start_load();
      for (int k = 0; k < 17; k++) begin
         bus.iCoeffValid = 1'b1;
         bus.iCoeffData = 16'(16'h0100 + k);
         guard = 0;
         while (bus.oCoeffReady !== 1'b1 && guard < 8) begin
            @(negedge clk);
            guard++;
         end
         total_cnt++;
         if (guard >= 8) begin
            $display("FAIL symm_stall k=%0d got ready=%b want 1 within 8 cycles", k, bus.oCoeffReady);
         end else pass_cnt++;
         @(negedge clk);
      end
      bus.iCoeffValid = 1'b0;
      repeat (4) @(negedge clk);
      bad = 0;
      for (int k = 0; k < 17; k++) begin
         if (ram_q[k] != 16'(16'h0100 + k) || ram_q[32 - k] != 16'(16'h0100 + k)) bad++;
      end
      total_cnt++;
      if (bad != 0) begin
         $display("FAIL symm_data got bad_pairs=%0d want 0", bad);
      end else pass_cnt++;
      total_cnt++;
      if (ram_hits[16] != 1 || wr_total !== 33 || done_cnt !== 1) begin
         $display("FAIL symm_totals got hits16=%0d writes=%0d done_pulses=%0d want 1 33 1",
                  ram_hits[16], wr_total, done_cnt);
      end else pass_cnt++;
   endtask
`endif

   initial begin
      test_reset();
`ifdef COEFF_LOADER_SYMM_EN
      test_symm();
`else
      test_back_to_back();
      test_toggle();
      test_timeout();
      test_reset_midload();
      test_start_ignored();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
